int_collector: RTL and testbench
================================

# int_collector

Host-side collector for the per-source interrupt controllers. It captures rising edges on up to NUM_SRC `int_out` lines into a pending register and arbitrates among unmasked pending sources. It presents one interrupt ID at a time to the host over a req/ack/done handshake, and returns a one-cycle `int_clr` pulse to the serviced source's `int_state_rd` input, closing the loop from the source end.

## Interface
- NUM_SRC, 8, number of interrupt sources (2..32)
- ID_W, $clog2(NUM_SRC), ID width; derived, not overridden
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- int_in  in  NUM_SRC  interrupt lines from source `int_out`
- src_mask  in  NUM_SRC  1 = source excluded from arbitration (still latched)
- irq_req  out  1  request to host
- irq_id  out  ID_W  ID of requested source; valid while irq_req=1
- irq_ack  in  1  host accepts current irq_id
- irq_done  in  1  host finished servicing
- int_clr  out  NUM_SRC  one-hot one-cycle clear pulse to the serviced source
- pending  out  NUM_SRC  pending register, readable
- busy  out  1  1 in REQ or SERV

## Operation
- Edge capture:
  - `int_in_d` registers `int_in`.
  - `pending[i]` sets when int_in[i]=1 and int_in_d[i]=0.
  - A level held high yields exactly one pending event.
- Pending clear: only at ack of source i. If a set and a clear hit the same bit in one cycle, set wins; the bit stays 1.
- Eligible vector = pending & ~src_mask.
- Arbitration: lowest eligible index wins (see Configuration for the alternative).
- FSM states (encoding in package):
  - IDLE:
    - If eligible != 0: latch the winner into irq_id, go to REQ.
    - Otherwise stay.
  - REQ:
    - irq_req=1; irq_id is frozen, with no preemption by higher-priority arrivals and no effect from later mask changes.
    - On irq_ack: clear pending[irq_id], pulse int_clr[irq_id], go to SERV.
  - SERV:
    - irq_req=0.
    - On irq_done: go to IDLE.
- Ignored inputs:
  - irq_ack outside REQ.
  - irq_done outside SERV.
  - irq_ack and irq_done asserted together in REQ are treated as ack only.
- Reset values:
  - irq_req=0, irq_id=0, int_clr=0, pending=0, busy=0, state=IDLE.
  - int_in_d=0, so an input already high at reset release is captured as an edge on the first cycle.
- Reset mid-operation (any state): returns to IDLE and discards all pending events. No int_clr pulse is generated.

## Timing
- int_in rise sampled at edge k → pending bit set after edge k.
- FSM enters REQ at edge k+1 → irq_req=1 two cycles after the rise.
- irq_ack sampled at edge m → after edge m: irq_req=0, pending bit=0, int_clr high for exactly one cycle.
- irq_done sampled at edge n → IDLE after n. Next irq_req rises no earlier than after edge n+1.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- INT_COLLECTOR_RR_EN:
  - Defined: round-robin arbitration.
    - Pointer resets to 0.
    - After a grant to ID g, the pointer becomes (g+1) mod NUM_SRC.
    - Winner = first eligible index at or above the pointer, wrapping around.
  - Undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Structure
- Package int_collector_pkg holds:
  - FSM state enum (IDLE, REQ, SERV).
  - Maximum NUM_SRC constant.
  - ID width function.
- One sub-module, int_collector_arb:
  - Purely combinational.
  - Inputs: eligible vector, pointer. Outputs: winner ID and valid.
  - Contains the RR/fixed selection under the macro.
- The top holds the edge capture, pending register, FSM and the pointer register.

## Test plan
All scenarios use NUM_SRC=8.
- Reset: rst high 3 cycles, int_in=8'h00 → irq_req=0, irq_id=0, int_clr=8'h00, pending=8'h00, busy=0.
- Single source: int_in[3] rises → pending=8'h08 after 1 edge; irq_req=1 with irq_id=3 after 2; ack → int_clr=8'h08 for 1 cycle, pending=8'h00; done → busy=0.
- Simultaneous sources: int_in 8'h00→8'h24 → grants id 2 then id 5; int_in held at 8'h24 produces no further requests.
- Masking: src_mask=8'h04, int_in[2] rises → pending=8'h04, irq_req stays 0; src_mask=8'h00 → irq_req=1, irq_id=2 next cycle.
- Set/clear collision: int_in[1] re-rises in the cycle ack for id 1 is sampled → pending[1] remains 1; after done, a second request with irq_id=1 follows.
- Arbitration mode: sources 0 and 1 re-pulsed before every ack → with INT_COLLECTOR_RR_EN grants go 0,1,0,1; without it, grants go 0,0,0.

Source files
------------

// File: rtl/int_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_collector_pkg
// Description : Shared types and helpers for the interrupt collector.
//               - state_t       : collector FSM state encoding
//               - c_MAX_NUM_SRC : largest supported source count
//               - id_width()    : ID width for a given source count
// Revision    : 1.0 - initial release
// ============================================================================
package int_collector_pkg;

    localparam int c_MAX_NUM_SRC = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    // Never narrower than one bit, so a two-source build still has an ID.
    function automatic int id_width(input int num_src);
        return (num_src > 2) ? $clog2(num_src) : 1;
    endfunction

endpackage : int_collector_pkg
`default_nettype wire

// File: rtl/int_collector_arb.sv
`default_nettype none
// ============================================================================
// Module      : int_collector_arb
// Description : Combinational winner selection among eligible sources.
//               INT_COLLECTOR_RR_EN defined   : round-robin, search starts at
//                                               i_ptr and wraps around.
//               INT_COLLECTOR_RR_EN undefined : fixed priority, lowest index
//                                               wins; i_ptr is ignored.
// Ports       : i_eligible  eligible (pending and unmasked) vector
//               i_ptr       round-robin start index
//               o_winner    selected source ID
//               o_valid     1 when any source is eligible
// Revision    : 1.0 - initial release
// ============================================================================
module int_collector_arb
    import int_collector_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] i_eligible,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_valid
);

`ifdef INT_COLLECTOR_RR_EN
    int              w_sum;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // Wrap explicitly so non-power-of-two source counts work.
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NUM_SRC) begin
                w_sum = w_sum - NUM_SRC;
            end
            w_idx = ID_W'(w_sum);
            if (!o_valid && i_eligible[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        // Descending scan: the last hit, which is the lowest index, wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_eligible[k]) begin
                o_winner = ID_W'(k);
                o_valid  = 1'b1;
            end
        end
    end
`endif

endmodule : int_collector_arb
`default_nettype wire

// File: rtl/int_collector.sv
`default_nettype none
// ============================================================================
// Module      : int_collector
// Description : Captures rising edges of up to NUM_SRC interrupt lines into a
//               pending register, arbitrates among unmasked pending sources
//               and presents one ID at a time to the host (req/ack/done).
//               A one-cycle one-hot int_clr pulse is returned to the source
//               whose request was acknowledged.
//               Build option INT_COLLECTOR_RR_EN selects round-robin
//               arbitration; default is fixed lowest-index priority.
// Ports       : clk, rst       clock, synchronous active-high reset
//               int_in         interrupt lines (rising edge = event)
//               src_mask       1 = excluded from arbitration, still latched
//               irq_req/irq_id request and ID to host
//               irq_ack        host accepts current ID
//               irq_done       host finished servicing
//               int_clr        one-hot clear pulse to serviced source
//               pending        pending register
//               busy           1 while in REQ or SERV
// Revision    : 1.0 - initial release
// ============================================================================
module int_collector
    import int_collector_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    localparam int ID_W    = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_in,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic [NUM_SRC-1:0] int_clr,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    state_t             r_state_q,    w_state_d;
    logic [NUM_SRC-1:0] r_int_in_d_q;
    logic [NUM_SRC-1:0] r_pending_q,  w_pending_d;
    logic [NUM_SRC-1:0] r_int_clr_q,  w_int_clr_d;
    logic [ID_W-1:0]    r_irq_id_q,   w_irq_id_d;
    logic               r_irq_req_q,  w_irq_req_d;
    logic               r_busy_q,     w_busy_d;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_id_onehot;
    logic [NUM_SRC-1:0] w_clear;
    logic [ID_W-1:0]    w_ptr;
    logic [ID_W-1:0]    w_winner;
    logic               w_valid;

    assign w_rise      = int_in & ~r_int_in_d_q;
    assign w_eligible  = r_pending_q & ~src_mask;
    assign w_id_onehot = NUM_SRC'(1) << r_irq_id_q;

`ifdef INT_COLLECTOR_RR_EN
    logic [ID_W-1:0] r_ptr_q, w_ptr_d;
    assign w_ptr = r_ptr_q;

    // Pointer advances when a winner is latched into irq_id.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (r_state_q == ST_IDLE && w_valid) begin
            w_ptr_d = (w_winner == ID_W'(NUM_SRC - 1)) ? '0 : w_winner + ID_W'(1);
        end
    end
`else
    assign w_ptr = '0;
`endif

    int_collector_arb #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (w_ptr),
        .o_winner   (w_winner),
        .o_valid    (w_valid)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_irq_id_d  = r_irq_id_q;
        w_irq_req_d = r_irq_req_q;
        w_int_clr_d = '0;
        w_clear     = '0;
        unique case (r_state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    w_irq_id_d  = w_winner;
                    w_irq_req_d = 1'b1;
                    w_state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // irq_done in the same cycle is ignored: ack takes priority.
                if (irq_ack) begin
                    w_clear     = w_id_onehot;
                    w_int_clr_d = w_id_onehot;
                    w_irq_req_d = 1'b0;
                    w_state_d   = ST_SERV;
                end
            end
            ST_SERV: begin
                if (irq_done) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d   = ST_IDLE;
                w_irq_req_d = 1'b0;
            end
        endcase
        // Set is applied after clear so a coincident new edge survives.
        w_pending_d = (r_pending_q & ~w_clear) | w_rise;
        w_busy_d    = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_int_in_d_q <= '0;
            r_pending_q  <= '0;
            r_int_clr_q  <= '0;
            r_irq_id_q   <= '0;
            r_irq_req_q  <= 1'b0;
            r_busy_q     <= 1'b0;
`ifdef INT_COLLECTOR_RR_EN
            r_ptr_q      <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_int_in_d_q <= int_in;
            r_pending_q  <= w_pending_d;
            r_int_clr_q  <= w_int_clr_d;
            r_irq_id_q   <= w_irq_id_d;
            r_irq_req_q  <= w_irq_req_d;
            r_busy_q     <= w_busy_d;
`ifdef INT_COLLECTOR_RR_EN
            r_ptr_q      <= w_ptr_d;
`endif
        end
    end

    assign irq_req = r_irq_req_q;
    assign irq_id  = r_irq_id_q;
    assign int_clr = r_int_clr_q;
    assign pending = r_pending_q;
    assign busy    = r_busy_q;

endmodule : int_collector
`default_nettype wire

// File: tb/tb_int_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_collector
// Description : Directed self-checking bench for int_collector (NUM_SRC=8).
//               Expected grant order depends on INT_COLLECTOR_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] int_in;
    logic [7:0] src_mask;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       irq_done;
    logic [7:0] int_clr;
    logic [7:0] pending;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_grant [4];

    always #5 clk = ~clk;

    int_collector #(.NUM_SRC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .int_in   (int_in),
        .src_mask (src_mask),
        .irq_req  (irq_req),
        .irq_id   (irq_id),
        .irq_ack  (irq_ack),
        .irq_done (irq_done),
        .int_clr  (int_clr),
        .pending  (pending),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef INT_COLLECTOR_RR_EN
        exp_grant = '{3'd0, 3'd1, 3'd0, 3'd1};
`else
        exp_grant = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        rst = 1'b1; int_in = 8'h00; src_mask = 8'h00; irq_ack = 1'b0; irq_done = 1'b0;

        // Reset
        repeat (3) tick();
        chk("rst_req",     irq_req, 0);
        chk("rst_id",      irq_id,  0);
        chk("rst_clr",     int_clr, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_busy",    busy,    0);
        rst = 1'b0;

        // Single source 3
        int_in = 8'h08;
        tick();
        chk("single_pend",  pending, 8'h08);
        chk("single_req0",  irq_req, 0);
        tick();
        chk("single_req",   irq_req, 1);
        chk("single_id",    irq_id,  3);
        chk("single_busy",  busy,    1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("single_clr",   int_clr, 8'h08);
        chk("single_pclr",  pending, 8'h00);
        chk("single_reqlo", irq_req, 0);
        tick();
        chk("single_clr1",  int_clr, 8'h00);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk("single_idle",  busy,    0);
        int_in = 8'h00;
        tick();

        // Simultaneous sources 2 and 5
        int_in = 8'h24;
        tick();
        chk("sim_pend",   pending, 8'h24);
        tick();
        chk("sim_req_a",  irq_req, 1);
        chk("sim_id_a",   irq_id,  2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("sim_clr_a",  int_clr, 8'h04);
        chk("sim_pend_a", pending, 8'h20);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        chk("sim_req_b",  irq_req, 1);
        chk("sim_id_b",   irq_id,  5);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("sim_clr_b",  int_clr, 8'h20);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        repeat (3) begin
            tick();
            chk("sim_hold_req",  irq_req, 0);
            chk("sim_hold_pend", pending, 8'h00);
        end
        int_in = 8'h00;
        tick();

        // Masking
        src_mask = 8'h04;
        int_in   = 8'h04;
        tick();
        chk("mask_pend", pending, 8'h04);
        tick();
        tick();
        chk("mask_req0", irq_req, 0);
        src_mask = 8'h00;
        tick();
        chk("mask_req",  irq_req, 1);
        chk("mask_id",   irq_id,  2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        int_in = 8'h00;
        tick();

        // Set/clear collision on source 1
        int_in = 8'h02;
        tick();
        tick();
        chk("col_req",  irq_req, 1);
        chk("col_id",   irq_id,  1);
        int_in = 8'h00;
        tick();
        int_in  = 8'h02;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("col_pend", pending, 8'h02);
        chk("col_clr",  int_clr, 8'h02);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        chk("col_req2", irq_req, 1);
        chk("col_id2",  irq_id,  1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        int_in = 8'h00;
        tick();
        chk("col_pend_end", pending, 8'h00);

        // Arbitration mode: sources 0 and 1 re-pulsed during each service
        int_in = 8'h03;
        tick();
        int_in = 8'h00;
        tick();
        for (int r = 0; r < 4; r++) begin
            chk("arb_req", irq_req, 1);
            chk("arb_id",  irq_id,  exp_grant[r]);
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            int_in  = 8'h03;
            tick();
            int_in   = 8'h00;
            irq_done = 1'b1;
            tick();
            irq_done = 1'b0;
            tick();
        end

        // Reset while a request is outstanding
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req",  irq_req, 0);
        chk("mid_rst_pend", pending, 8'h00);
        chk("mid_rst_clr",  int_clr, 8'h00);
        chk("mid_rst_busy", busy,    0);
        tick();
        chk("mid_rst_idle", irq_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_int_collector
`default_nettype wire
